// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with synchronous byte-lane writes and an asynchronous word read.
// Contents are deliberately left unreset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with WAIT_CYCLES wait states and a one-cycle acknowledge.
// Define DMEM_ERR_CHECK_EN to fault misaligned and out-of-range addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              capWe_q, capErr_q;
  logic [IDX_W-1:0]  capIdx_q;
  logic [WORD_W-1:0] capWdata_q;
  logic [BE_W-1:0]   capBe_q;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              accept, respEnter, reqErr, arrWe;
  logic              curWe, curErr;
  logic [IDX_W-1:0]  curIdx;
  logic [WORD_W-1:0] curWdata, arrRdata;
  logic [BE_W-1:0]   curBe;

  assign ready_o = (state_q == IDLE);
  assign accept  = req_i && ready_o;

`ifdef DMEM_ERR_CHECK_EN
  assign reqErr = (addr_i[1:0] != 2'b00) || (addr_i >= WORD_W'(DEPTH_WORDS * 4));
`else
  logic unusedAddr;
  assign unusedAddr = ^{addr_i[1:0], addr_i[WORD_W-1:2+IDX_W]};
  assign reqErr     = 1'b0;
`endif

  // With zero wait states RESP is entered on the accept edge, before capture lands.
  assign curWe    = ready_o ? we_i : capWe_q;
  assign curErr   = ready_o ? reqErr : capErr_q;
  assign curIdx   = ready_o ? addr_i[2 +: IDX_W] : capIdx_q;
  assign curWdata = ready_o ? wdata_i : capWdata_q;
  assign curBe    = ready_o ? be_i : capBe_q;

  assign respEnter = (state_d == RESP) && (state_q != RESP);
  assign arrWe     = respEnter && curWe && !curErr;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (arrWe),
    .idx_i  (curIdx),
    .wdata_i(curWdata),
    .be_i   (curBe),
    .rdata_o(arrRdata)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          count_d = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (respEnter) begin
      rdata_d = (curWe || curErr) ? '0 : arrRdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rdata_q    <= '0;
      capWe_q    <= 1'b0;
      capErr_q   <= 1'b0;
      capIdx_q   <= '0;
      capWdata_q <= '0;
      capBe_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      if (accept) begin
        capWe_q    <= we_i;
        capErr_q   <= reqErr;
        capIdx_q   <= addr_i[2 +: IDX_W];
        capWdata_q <= wdata_i;
        capBe_q    <= be_i;
      end
    end
  end

  assign ack_o   = (state_q == RESP);
  assign err_o   = (state_q == RESP) && capErr_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance A has two wait states, instance B has none.
// Fault expectations follow DMEM_ERR_CHECK_EN when the bench is built with it.
module tb_dmem_responder;

  localparam int DEPTH  = 64;
  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;

  typedef struct {
    int          d;
    logic [31:0] expRdata;
    logic        expErr;
    int          expAck;
    string       name;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    string       name;
  } stim_t;

  logic             clk = 1'b0;
  logic             rstN;
  logic [1:0]       req;
  logic             weIn;
  logic [31:0]      addrIn, wdataIn;
  logic [3:0]       beIn;
  logic [1:0]       ready, ack, err;
  logic [1:0][31:0] rdata;

  int          cycleCnt = 0;
  int          nChecks  = 0;
  int          nFails   = 0;
  exp_t        sbQ[$];
  logic [31:0] model [2][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dutA (
    .clk_i(clk), .rst_ni(rstN), .req_i(req[0]), .we_i(weIn), .addr_i(addrIn),
    .wdata_i(wdataIn), .be_i(beIn), .ready_o(ready[0]), .ack_o(ack[0]),
    .rdata_o(rdata[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_B)) dutB (
    .clk_i(clk), .rst_ni(rstN), .req_i(req[1]), .we_i(weIn), .addr_i(addrIn),
    .wdata_i(wdataIn), .be_i(beIn), .ready_o(ready[1]), .ack_o(ack[1]),
    .rdata_o(rdata[1]), .err_o(err[1])
  );

  function automatic int waitOf(input int d);
    return (d == 0) ? WAIT_A : WAIT_B;
  endfunction

  function automatic bit faultOf(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: updates the word image and queues the expected acknowledge.
  task automatic pushExpected(input int d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input int expAck, input string name);
    exp_t e;
    int   idx;
    bit   f;
    idx = int'(addr[7:2]);
    f   = faultOf(addr);
    e.d = d; e.expErr = f; e.expAck = expAck; e.name = name;
    if (we) begin
      e.expRdata = '0;
      if (!f) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model[d][idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end else begin
      e.expRdata = f ? 32'h0 : model[d][idx];
    end
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input string name);
    int n = 0;
    @(negedge clk);
    while (ready[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    weIn = we; addrIn = addr; wdataIn = wdata; beIn = be;
    req[d] = 1'b1;
    pushExpected(d, we, addr, wdata, be, cycleCnt + 1 + waitOf(d), name);
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  task automatic waitAck(input int d, output bit seen);
    int n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      if (ack[d] === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; req = 2'b00;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nChecks++;
      if (ready[d] !== 1'b1 || ack[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        nFails++;
        $display("[TB] FAIL reset_values dut%0d: ready=%b ack=%b err=%b rdata=%h, expected 1 0 0 0",
                 d, ready[d], ack[d], err[d], rdata[d]);
      end
    end
    weIn = 1'b1; addrIn = 32'h10; wdataIn = 32'h0BAD0BAD; beIn = 4'hF; req = 2'b11;
    repeat (3) begin
      @(negedge clk);
      nChecks++;
      if (ack !== 2'b00 || ready !== 2'b11) begin
        nFails++;
        $display("[TB] FAIL req_in_reset: ack=%b ready=%b, expected 00 11", ack, ready);
      end
    end
    req = 2'b00; rstN = 1'b1;
    @(negedge clk);
    nChecks++;
    if (ack !== 2'b00 || ready !== 2'b11) begin
      nFails++;
      $display("[TB] FAIL after_reset: ack=%b ready=%b, expected 00 11", ack, ready);
    end
  endtask

  task automatic test_basic();
    stim_t tbl[$];
    exp_t  e;
    bit    seen;
    tbl.push_back(stim_t'{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "store_0x10"});
    tbl.push_back(stim_t'{1'b0, 32'h10, 32'h0, 4'h0, "load_0x10"});
    foreach (tbl[i]) begin
      applyStimulus(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].name);
      waitAck(0, seen);
      e = sbQ.pop_front();
      nChecks++;
      if (!seen || cycleCnt != e.expAck) begin
        nFails++;
        $display("[TB] FAIL %s ack_cycle: got %0d (seen=%0b), expected %0d", e.name, cycleCnt, seen, e.expAck);
      end
      nChecks++;
      if (err[0] !== e.expErr || rdata[0] !== e.expRdata) begin
        nFails++;
        $display("[TB] FAIL %s data: err=%b rdata=%h, expected err=%b rdata=%h",
                 e.name, err[0], rdata[0], e.expErr, e.expRdata);
      end
      @(negedge clk);
      nChecks++;
      if (ack[0] !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL %s ack_width: ack=%b one cycle later, expected 0", e.name, ack[0]);
      end
    end
  endtask

  task automatic test_byte_lanes();
    stim_t tbl[$];
    exp_t  e;
    bit    seen;
    tbl.push_back(stim_t'{1'b1, 32'h20, 32'h11223344, 4'hF, "lanes_fill"});
    tbl.push_back(stim_t'{1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "lanes_0101"});
    tbl.push_back(stim_t'{1'b0, 32'h20, 32'h0, 4'hF, "lanes_load"});
    tbl.push_back(stim_t'{1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, "lanes_be0"});
    tbl.push_back(stim_t'{1'b0, 32'h20, 32'h0, 4'h0, "lanes_load_after_be0"});
    foreach (tbl[i]) begin
      applyStimulus(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].name);
      waitAck(0, seen);
      e = sbQ.pop_front();
      nChecks++;
      if (!seen || cycleCnt != e.expAck) begin
        nFails++;
        $display("[TB] FAIL %s ack_cycle: got %0d (seen=%0b), expected %0d", e.name, cycleCnt, seen, e.expAck);
      end
      nChecks++;
      if (err[0] !== e.expErr || rdata[0] !== e.expRdata) begin
        nFails++;
        $display("[TB] FAIL %s data: err=%b rdata=%h, expected err=%b rdata=%h",
                 e.name, err[0], rdata[0], e.expErr, e.expRdata);
      end
    end
  endtask

  // req_i stays high across two requests; the store's data lines change during WAIT.
  task automatic test_back_to_back();
    exp_t e;
    int   n = 0, accepts = 0, lastAcc = -100;
    bit   prevAcc;
    @(negedge clk);
    while (ready[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    weIn = 1'b1; addrIn = 32'h30; wdataIn = 32'h13579BDF; beIn = 4'hF; req[0] = 1'b1;
    pushExpected(0, 1'b1, 32'h30, 32'h13579BDF, 4'hF, cycleCnt + 1 + WAIT_A, "b2b_store");
    pushExpected(0, 1'b0, 32'h30, 32'h0, 4'h0, cycleCnt + 1 + 2 * WAIT_A + 2, "b2b_load");
    n = 0;
    while (n < 40 && (accepts < 2 || sbQ.size() != 0)) begin
      prevAcc = (req[0] === 1'b1) && (ready[0] === 1'b1);
      @(negedge clk);
      n++;
      if (prevAcc) begin
        accepts++;
        lastAcc = cycleCnt;
        if (accepts == 1) begin
          weIn = 1'b0; wdataIn = 32'hFFFFFFFF; beIn = 4'h0;
        end else begin
          req[0] = 1'b0;
        end
      end
      nChecks++;
      if (ready[0] !== ((cycleCnt - lastAcc) > WAIT_A)) begin
        nFails++;
        $display("[TB] FAIL b2b_ready at cycle %0d: got %b, expected %b",
                 cycleCnt, ready[0], ((cycleCnt - lastAcc) > WAIT_A));
      end
      if (ack[0] === 1'b1) begin
        if (sbQ.size() == 0) begin
          nChecks++; nFails++;
          $display("[TB] FAIL b2b_spurious_ack at cycle %0d: got ack=1, expected 0", cycleCnt);
        end else begin
          e = sbQ.pop_front();
          nChecks++;
          if (cycleCnt != e.expAck || err[0] !== e.expErr || rdata[0] !== e.expRdata) begin
            nFails++;
            $display("[TB] FAIL %s: cycle=%0d err=%b rdata=%h, expected cycle=%0d err=%b rdata=%h",
                     e.name, cycleCnt, err[0], rdata[0], e.expAck, e.expErr, e.expRdata);
          end
        end
      end
    end
    req[0] = 1'b0;
    nChecks++;
    if (accepts != 2 || sbQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL b2b_complete: accepts=%0d pending=%0d, expected 2 0", accepts, sbQ.size());
    end
    sbQ.delete();
  endtask

  task automatic test_wait0();
    stim_t tbl[$];
    exp_t  e;
    bit    seen;
    tbl.push_back(stim_t'{1'b1, 32'h3C, 32'h0F0F1234, 4'hF, "w0_store"});
    tbl.push_back(stim_t'{1'b0, 32'h3C, 32'h0, 4'h0, "w0_load"});
    tbl.push_back(stim_t'{1'b1, 32'h3C, 32'h00AA0000, 4'b0100, "w0_store_lane2"});
    tbl.push_back(stim_t'{1'b0, 32'h3C, 32'h0, 4'h0, "w0_load_lane2"});
    foreach (tbl[i]) begin
      applyStimulus(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].name);
      waitAck(1, seen);
      e = sbQ.pop_front();
      nChecks++;
      if (!seen || cycleCnt != e.expAck) begin
        nFails++;
        $display("[TB] FAIL %s ack_cycle: got %0d (seen=%0b), expected %0d", e.name, cycleCnt, seen, e.expAck);
      end
      nChecks++;
      if (err[1] !== e.expErr || rdata[1] !== e.expRdata) begin
        nFails++;
        $display("[TB] FAIL %s data: err=%b rdata=%h, expected err=%b rdata=%h",
                 e.name, err[1], rdata[1], e.expErr, e.expRdata);
      end
    end
  endtask

  task automatic test_addr_limits();
    stim_t tbl[$];
    exp_t  e;
    bit    seen;
    tbl.push_back(stim_t'{1'b1, 32'h00, 32'hCAFEF00D, 4'hF, "lim_store_0x00"});
    tbl.push_back(stim_t'{1'b0, 32'h100, 32'h0, 4'h0, "lim_load_top"});
    tbl.push_back(stim_t'{1'b1, 32'h13, 32'h12345678, 4'hF, "lim_store_0x13"});
    tbl.push_back(stim_t'{1'b1, 32'h100, 32'h87654321, 4'hF, "lim_store_top"});
    tbl.push_back(stim_t'{1'b0, 32'h10, 32'h0, 4'h0, "lim_load_0x10"});
    tbl.push_back(stim_t'{1'b0, 32'h00, 32'h0, 4'h0, "lim_load_0x00"});
    tbl.push_back(stim_t'{1'b0, 32'h13, 32'h0, 4'h0, "lim_load_0x13"});
    foreach (tbl[i]) begin
      applyStimulus(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].name);
      waitAck(0, seen);
      e = sbQ.pop_front();
      nChecks++;
      if (!seen || cycleCnt != e.expAck) begin
        nFails++;
        $display("[TB] FAIL %s ack_cycle: got %0d (seen=%0b), expected %0d", e.name, cycleCnt, seen, e.expAck);
      end
      nChecks++;
      if (err[0] !== e.expErr || rdata[0] !== e.expRdata) begin
        nFails++;
        $display("[TB] FAIL %s data: err=%b rdata=%h, expected err=%b rdata=%h",
                 e.name, err[0], rdata[0], e.expErr, e.expRdata);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    bit   seen;
    int   n = 0;
    applyStimulus(0, 1'b1, 32'h08, 32'h0BADF00D, 4'hF, "rmw_prior");
    waitAck(0, seen);
    e = sbQ.pop_front();
    @(negedge clk);
    while (ready[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    weIn = 1'b1; addrIn = 32'h08; wdataIn = 32'h00000055; beIn = 4'hF; req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    nChecks++;
    if (ready[0] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rmw_accepted: ready=%b, expected 0", ready[0]);
    end
    rstN = 1'b0;
    #1;
    nChecks++;
    if (ready[0] !== 1'b1 || ack[0] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rmw_in_reset: ready=%b ack=%b, expected 1 0", ready[0], ack[0]);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (4) begin
      @(negedge clk);
      nChecks++;
      if (ack[0] !== 1'b0 || ready[0] !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL rmw_no_ack: ack=%b ready=%b, expected 0 1", ack[0], ready[0]);
      end
    end
    applyStimulus(0, 1'b0, 32'h08, 32'h0, 4'h0, "rmw_load_0x08");
    waitAck(0, seen);
    e = sbQ.pop_front();
    nChecks++;
    if (!seen || cycleCnt != e.expAck || rdata[0] !== e.expRdata || err[0] !== e.expErr) begin
      nFails++;
      $display("[TB] FAIL %s: seen=%0b cycle=%0d rdata=%h err=%b, expected cycle=%0d rdata=%h err=%b",
               e.name, seen, cycleCnt, rdata[0], err[0], e.expAck, e.expRdata, e.expErr);
    end
  endtask

  initial begin
    rstN = 1'b0; req = 2'b00; weIn = 1'b0; addrIn = '0; wdataIn = '0; beIn = '0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
    test_wait0();
    test_addr_limits();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle datapath's load/store port. Accepts one load or store request at a time over a valid/ready handshake, models a configurable number of wait states, performs byte-lane writes and word reads on an internal word array, and returns a one-cycle acknowledge carrying read data. Replaces the ideal zero-latency RAM so the core can be exercised against realistic memory timing.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words; power of two, 4..4096
- WAIT_CYCLES, 2: wait states between accept and acknowledge; 0..15
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- req_i  input  1  request valid
- we_i  input  1  1 = store, 0 = load
- addr_i  input  32  byte address
- wdata_i  input  32  store data
- be_i  input  4  store byte enables, lane 0 = bits 7:0 (little-endian)
- ready_o  output  1  responder can accept a request this cycle
- ack_o  output  1  one-cycle completion pulse (load and store)
- rdata_o  output  32  load data, valid only when ack_o && captured we = 0
- err_o  output  1  request faulted, valid only with ack_o

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- ready_o = (state == IDLE), combinational from state.
- IDLE: on req_i && ready_o, capture we, addr, wdata, be; load wait counter with WAIT_CYCLES; go WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: counter decrements each cycle; at counter == 1, go RESP.
- RESP transition edge: store writes enabled lanes of word addr[2 +: log2(DEPTH_WORDS)]; load registers that word into rdata_o. RESP asserts ack_o for exactly one cycle, then IDLE.
- Store with be = 0000: no array change, still acknowledged.
- Load ignores be. rdata_o holds last load value until next load completes; 0 after store.
- req_i, addr_i etc. ignored outside IDLE; captured values immune to input changes during WAIT.
- Array contents not reset; only control state and output registers reset.

## Timing
- Request accepted at edge k; ack_o high in cycle k+1+WAIT_CYCLES; ready_o high again the following cycle. Throughput: one request per WAIT_CYCLES+2 cycles.
- Reset values: ready_o = 1 (IDLE), ack_o = 0, err_o = 0, rdata_o = 0, counter = 0.
- Reset mid-WAIT: FSM to IDLE immediately; pending store discarded (array unchanged); no ack_o.
- Requests while rst_ni low: ignored.
- Back-to-back store then load to same word: load returns newly stored data.

## Configuration
- DMEM_ERR_CHECK_EN defined: request faults if addr[1:0] != 0 or addr >= DEPTH_WORDS*4. Faulting store does not write; faulting load returns rdata_o = 0; err_o = 1 with ack_o. Latency unchanged.
- Undefined: no checks, addr[1:0] ignored, word index wraps modulo DEPTH_WORDS, err_o tied 0.

## Structure
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), WORD_W = 32, BE_W = 4, counter width constant (4 bits).
- Sub-module dmem_array: DEPTH_WORDS x 32 storage, synchronous byte-lane write, word read; responder owns FSM, counter, capture and output registers.

## Test plan
- Reset, WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, be=1111 -> accepted edge k, ack_o in cycle k+3, err_o=0; load 0x10 -> rdata_o = 0xDEADBEEF with ack_o.
- Byte lanes: word 0x20 = 0x11223344, store 0xAABBCCDD be=0101 -> load returns 0x11BB33DD.
- Handshake: hold req_i high continuously -> ready_o low from accept through ack cycle, second request accepted exactly one cycle after first ack_o.
- WAIT_CYCLES=0: store then load -> each ack_o one cycle after accept; load returns stored data.
- DMEM_ERR_CHECK_EN: store to 0x13 and to DEPTH_WORDS*4 -> ack_o with err_o=1, array unchanged; load 0x13 -> rdata_o=0, err_o=1. Without macro: load DEPTH_WORDS*4 returns word 0.
- Reset asserted during WAIT of store 0x55 to 0x08 -> no ack_o, ready_o=1, later load 0x08 returns prior contents.
